// File: rtl/dmem_access_unit.sv
// rtl/dmem_access_unit.sv - data-memory stage: byte/half/word access on an internal word RAM
module dmem_access_unit #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_size,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam logic [2:0]  SZ_B  = 3'b000;
    localparam logic [2:0]  SZ_H  = 3'b001;
    localparam logic [2:0]  SZ_W  = 3'b010;
    localparam logic [2:0]  SZ_BU = 3'b100;
    localparam logic [2:0]  SZ_HU = 3'b101;
    localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

    typedef enum logic [1:0] {IDLE, RD, RESP} state_t;

    state_t         state;
    state_t         state_nxt;
    logic           accept;
    logic           size_ok;
    logic           misaligned;
    logic           out_of_range;
    logic           req_err;
    logic [AW-1:0]  widx;
    logic [3:0]     be;
    logic [31:0]    wdata_rep;
    logic [31:0]    mem [DEPTH];
    logic [31:0]    rd_word;
    logic [1:0]     lane_q;
    logic [2:0]     size_q;
    logic [7:0]     byte_sel;
    logic [15:0]    half_sel;
    logic [31:0]    load_ext;

    assign accept = req_valid && req_ready;
    assign widx   = req_addr[AW+1:2];

    // Classify the request: legal size for direction, natural alignment, address range
    always_comb begin
        size_ok = 1'b0;
        case (req_size)
            SZ_B, SZ_H, SZ_W: size_ok = 1'b1;
            SZ_BU, SZ_HU:     size_ok = !req_we;
            default:          size_ok = 1'b0;
        endcase
        misaligned   = (((req_size == SZ_H) || (req_size == SZ_HU)) && req_addr[0])
                    || ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
        out_of_range = (req_addr >= ADDR_LIMIT);
        req_err      = !size_ok || misaligned || out_of_range;
    end

    // Store lane enables and store data replicated onto every lane it may land in
    always_comb begin
        be        = 4'b0000;
        wdata_rep = req_wdata;
        case (req_size)
            SZ_B: begin
                be        = 4'b0001 << req_addr[1:0];
                wdata_rep = {4{req_wdata[7:0]}};
            end
            SZ_H: begin
                be        = req_addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{req_wdata[15:0]}};
            end
            SZ_W: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Word RAM: stores commit at acceptance, loads capture the addressed word
    always_ff @(posedge clk) begin
        if (accept && !req_err) begin
            if (req_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem[widx][i*8 +: 8] <= wdata_rep[i*8 +: 8];
                    end
                end
            end else begin
                rd_word <= mem[widx];
            end
        end
    end

    // Lane selection and sign/zero extension of the captured word
    always_comb begin
        byte_sel = rd_word[{lane_q, 3'b000} +: 8];
        half_sel = lane_q[1] ? rd_word[31:16] : rd_word[15:0];
        case (size_q)
            SZ_B:    load_ext = {{24{byte_sel[7]}}, byte_sel};
            SZ_H:    load_ext = {{16{half_sel[15]}}, half_sel};
            SZ_BU:   load_ext = {24'b0, byte_sel};
            SZ_HU:   load_ext = {16'b0, half_sel};
            default: load_ext = rd_word;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (req_err || req_we) ? RESP : RD;
                end
            end
            RD:      state_nxt = RESP;
            RESP:    state_nxt = rsp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
    end

    // Response payload and load-side capture; payload holds while RESP waits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q    <= 2'b00;
            size_q    <= 3'b000;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lane_q    <= req_addr[1:0];
                        size_q    <= req_size;
                        rsp_rdata <= 32'h0;
                        rsp_err   <= req_err;
                    end
                end
                RD: begin
                    rsp_rdata <= load_ext;
                    rsp_err   <= 1'b0;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_rdata <= 32'h0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    rsp_rdata <= 32'h0;
                    rsp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb/tb_dmem_access_unit.sv - self-checking bench for dmem_access_unit
module tb_dmem_access_unit;

    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int NBYTE = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [2:0]  req_size = 3'b000;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] ram_m [NBYTE];

    dmem_access_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_size  (req_size),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic void add_vec(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                    input logic [2:0] size, input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.size = size;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endfunction

    // Reference: access rules computed byte-by-byte on a flat byte array
    function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [2:0] size, output logic [31:0] rdata, output logic err);
        int nbytes;
        logic legal;
        logic [31:0] val;
        legal  = (size == 3'd0 || size == 3'd1 || size == 3'd2) || (!we && (size == 3'd4 || size == 3'd5));
        nbytes = (size == 3'd0 || size == 3'd4) ? 1 : (size == 3'd2) ? 4 : 2;
        err    = !legal || (addr >= NBYTE) || (addr % nbytes != 0);
        rdata  = 32'h0;
        if (err) return;
        if (we) begin
            for (int i = 0; i < nbytes; i++) ram_m[addr + i] = wdata[i*8 +: 8];
        end else begin
            val = 32'h0;
            for (int i = 0; i < nbytes; i++) val = val | (32'(ram_m[addr + i]) << (8 * i));
            if (size < 3'd4 && nbytes < 4 && val[nbytes*8 - 1]) val = val | (32'hFFFF_FFFF << (8 * nbytes));
            rdata = val;
        end
    endfunction

    task automatic wait_ready(input string name);
        int n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (!req_ready) check({name, "_ready_timeout"}, 32'(req_ready), 32'h1);
    endtask

    // One full transaction with rsp_ready held high: latency, payload and return to idle
    task automatic do_req(input string name, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] size, input logic [31:0] exp_rdata, input logic exp_err);
        int lat;
        wait_ready(name);
        req_we = we; req_addr = addr; req_wdata = wdata; req_size = size;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = $urandom; req_wdata = $urandom;
        check({name, "_busy"}, 32'(req_ready), 32'h0);
        lat = 1;
        while (!rsp_valid && lat < 8) begin
            @(posedge clk); #1; lat++;
        end
        check({name, "_latency"}, 32'(lat), (we || exp_err) ? 32'd1 : 32'd2);
        check({name, "_rdata"}, rsp_rdata, exp_rdata);
        check({name, "_err"}, 32'(rsp_err), 32'(exp_err));
        @(posedge clk); #1;
        check({name, "_done"}, 32'({rsp_valid, req_ready}), 32'b01);
    endtask

    initial begin
        logic [31:0] exp_d;
        logic        exp_e;
        logic        we;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] held;
        int          n;

        // Directed vector table
        add_vec(1, 32'h60,  32'h0000_0003, 3'b010, 32'h0, 0);
        add_vec(0, 32'h60,  32'h0,         3'b010, 32'h0000_0003, 0);
        add_vec(1, 32'h10,  32'h80FF_7F01, 3'b010, 32'h0, 0);
        add_vec(0, 32'h13,  32'h0,         3'b000, 32'hFFFF_FF80, 0);
        add_vec(0, 32'h13,  32'h0,         3'b100, 32'h0000_0080, 0);
        add_vec(0, 32'h12,  32'h0,         3'b001, 32'hFFFF_80FF, 0);
        add_vec(0, 32'h10,  32'h0,         3'b101, 32'h0000_7F01, 0);
        add_vec(0, 32'h10,  32'h0,         3'b000, 32'h0000_0001, 0);
        add_vec(1, 32'h11,  32'h1234_56AB, 3'b000, 32'h0, 0);
        add_vec(0, 32'h10,  32'h0,         3'b010, 32'h80FF_AB01, 0);
        add_vec(1, 32'h12,  32'h0000_BEEF, 3'b001, 32'h0, 0);
        add_vec(0, 32'h10,  32'h0,         3'b010, 32'hBEEF_AB01, 0);
        add_vec(0, 32'h62,  32'h0,         3'b010, 32'h0, 1);
        add_vec(0, 32'h60,  32'h0,         3'b010, 32'h0000_0003, 0);
        add_vec(1, 32'h13,  32'h0000_FFFF, 3'b001, 32'h0, 1);
        add_vec(0, 32'h10,  32'h0,         3'b010, 32'hBEEF_AB01, 0);
        add_vec(0, 32'h400, 32'h0,         3'b010, 32'h0, 1);
        add_vec(1, 32'h10,  32'h0000_0000, 3'b100, 32'h0, 1);
        add_vec(0, 32'h10,  32'h0,         3'b010, 32'hBEEF_AB01, 0);
        add_vec(0, 32'h10,  32'h0,         3'b011, 32'h0, 1);
        add_vec(1, 32'h60,  32'h0000_DEAD, 3'b011, 32'h0, 1);
        add_vec(0, 32'h60,  32'h0,         3'b010, 32'h0000_0003, 0);
        add_vec(1, 32'h3FC, 32'hCAFE_F00D, 3'b010, 32'h0, 0);
        add_vec(0, 32'h3FF, 32'h0,         3'b100, 32'h0000_00CA, 0);
        add_vec(0, 32'h3FE, 32'h0,         3'b001, 32'hFFFF_CAFE, 0);
        add_vec(0, 32'h3FC, 32'h0,         3'b010, 32'hCAFE_F00D, 0);

        // Reset state
        #12;
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err",   32'(rsp_err), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_req_ready", 32'(req_ready), 32'h1);

        for (int i = 0; i < vecs.size(); i++) begin
            do_req($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   vecs[i].size, vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // Backpressure: response held while rsp_ready is low
        rsp_ready = 1'b0;
        wait_ready("bp");
        req_we = 0; req_addr = 32'h10; req_size = 3'b010; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 8) begin
            @(posedge clk); #1; n++;
        end
        check("bp_latency", 32'(n), 32'd2);
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", 32'(rsp_valid), 32'h1);
            check("bp_rdata", rsp_rdata, 32'hBEEF_AB01);
            check("bp_ready", 32'(req_ready), 32'h0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", 32'({rsp_valid, req_ready}), 32'b01);

        // Reset in RD drops the load; the earlier store survives
        do_req("rst_sw", 1, 32'h20, 32'h5A5A_A5A5, 3'b010, 32'h0, 0);
        req_we = 0; req_addr = 32'h20; req_size = 3'b010; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("mid_in_rd", 32'(rsp_valid), 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_valid_low", 32'(rsp_valid), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("mid_no_rsp", 32'(rsp_valid), 32'h0);
            check("mid_ready", 32'(req_ready), 32'h1);
        end
        do_req("rst_lw", 0, 32'h20, 32'h0, 3'b010, 32'h5A5A_A5A5, 0);

        // Randomized phase against the byte-array model
        for (int w = 0; w < DEPTH; w++) begin
            addr = 32'(w * 4);
            model(1'b1, addr, $urandom, 3'b010, exp_d, exp_e);
            held = {ram_m[addr + 3], ram_m[addr + 2], ram_m[addr + 1], ram_m[addr]};
            do_req("init", 1, addr, held, 3'b010, exp_d, exp_e);
        end
        for (int i = 0; i < 300; i++) begin
            we   = ($urandom_range(0, 2) == 0);
            size = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0:       addr = 32'($urandom_range(NBYTE, NBYTE + 64));
                1:       addr = $urandom;
                default: addr = 32'($urandom_range(0, NBYTE - 1));
            endcase
            held = $urandom;
            model(we, addr, held, size, exp_d, exp_e);
            do_req($sformatf("rnd%0d", i), we, addr, held, size, exp_d, exp_e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Data-memory stage directly downstream of load_store_instructions.
- Accepts one effective address plus load/store request per handshake and performs a byte/half/word access on an internal synchronous word RAM.
- Returns load data sign- or zero-extended, ready for writeback.
- Flags misaligned, out-of-range and illegal-size requests without touching memory.

Parameters:
- DEPTH, 256, number of 32-bit words in the RAM; valid byte addresses are 0 to DEPTH*4-1.
- AW, 8, word-index width; must satisfy 2**AW >= DEPTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte effective address (read1 + immediate from the upstream stage).
- req_wdata  input  32  store data; the low bytes are used for SB/SH.
- req_size  input  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  downstream accepts the response.
- rsp_rdata  output  32  extended load data; 0 for stores and errors.
- rsp_err  output  1  request rejected (misaligned, out of range, or illegal size).

Behaviour:
- Reset (async, rst_n=0):
  - state goes to IDLE.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - req_ready=1 once reset is released.
  - RAM contents are not reset.
- States: IDLE, RD, RESP. req_ready=1 only in IDLE. A request is accepted at edge N when req_valid && req_ready.
- Error check at acceptance (purely combinational on the request):
  - Misaligned: H/HU with addr[0]!=0, or W with addr[1:0]!=0.
  - Out of range: req_addr >= DEPTH*4.
  - Illegal size: any other req_size, including BU/HU with req_we=1.
- Error path: IDLE goes to RESP with rsp_err=1 and rsp_rdata=0. No RAM read or write occurs.
- Store path (no error):
  - At edge N, RAM[addr[AW+1:2]] is written with byte enables:
    - B: lane addr[1:0] gets wdata[7:0].
    - H: lanes {addr[1],0} and {addr[1],1} get wdata[15:0].
    - W: all four lanes.
  - IDLE goes to RESP; rsp_valid=1 after edge N, rsp_rdata=0, rsp_err=0.
- Load path (no error):
  - At edge N, the RAM word is registered and addr[1:0] and size are captured; IDLE goes to RD.
  - At edge N+1, rsp_rdata is registered: selected lane/halfword, sign-extended for B/H, zero-extended for BU/HU. RD goes to RESP.
  - rsp_valid=1 after edge N+1; total load latency is 2 cycles.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err are held stable while rsp_ready=0.
  - When rsp_ready=1, the next edge clears rsp_valid and returns to IDLE.
  - No back-to-back acceptance in the same edge; maximum throughput is 1 request per 2 cycles for stores and 1 per 3 for loads.
- req_* inputs are ignored outside the acceptance edge.
- A load immediately following a store to the same word must observe the stored data. This is guaranteed because the write completes at acceptance.
- Reset mid-operation:
  - Any in-flight RD/RESP is dropped and no response is emitted.
  - A store written at its acceptance edge remains in RAM.

Test Plan:
- Reset release, then SW addr 0x60 wdata 0x00000003 -> req_ready=0 for one cycle; rsp_valid after 1 edge with err=0. Then LW 0x60 -> rsp_valid 2 edges after acceptance, rsp_rdata=0x00000003.
- SW 0x10 wdata 0x80FF7F01, then:
  - LB 0x13 -> 0xFFFFFF80
  - LBU 0x13 -> 0x00000080
  - LH 0x12 -> 0xFFFF80FF
  - LHU 0x10 -> 0x00007F01
  - LB 0x10 -> 0x00000001
- SB 0x11 wdata 0x123456AB, then LW 0x10 -> 0x80FFAB01. SH 0x12 wdata 0x0000BEEF, then LW 0x10 -> 0xBEEFAB01.
- Error cases, each giving rsp_err=1, rsp_rdata=0, and RAM unchanged (verify by LW):
  - LW 0x62
  - SH 0x13
  - LW 0x400 with DEPTH=256
  - SBU (we=1, size=100)
  - size=011
- Backpressure: LW with rsp_ready=0 for 5 cycles -> rsp_valid and data stable, req_ready=0 throughout; rsp_ready=1 -> IDLE on the next edge.
- Reset mid-operation: assert rst_n=0 asynchronously in RD -> rsp_valid=0 immediately, no response after release, req_ready=1. A prior SW to 0x20 is still readable.
